// File: rtl/minisys_wb_stage.sv
// minisys_wb_stage: MEM/WB pipeline register with result select, load extraction/extension,
// misaligned-load detection and a retired-instruction counter.
module minisys_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 32,
    parameter bit ZERO_REG_HARDWIRED = 1,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallW,
    input  logic                  flushW,
    input  logic                  validM,
    input  logic                  reg_writeM,
    input  logic [1:0]            result_srcM,
    input  logic [2:0]            load_typeM,
    input  logic [OFF_W-1:0]      byte_offsetM,
    input  logic [REG_ADDR_W-1:0] write_regM,
    input  logic [DATA_W-1:0]     alu_outM,
    input  logic [DATA_W-1:0]     read_dataM,
    input  logic [DATA_W-1:0]     linkM,
    output logic                  validW,
    output logic                  reg_writeW,
    output logic [REG_ADDR_W-1:0] write_regW,
    output logic [DATA_W-1:0]     result_to_writeW,
    output logic                  load_misalignW,
    output logic [CNT_W-1:0]      retired_cntW
);
    logic                  valid_q, reg_write_q;
    logic [1:0]            src_q;
    logic [2:0]            lt_q;
    logic [OFF_W-1:0]      off_q;
    logic [REG_ADDR_W-1:0] wr_q;
    logic [DATA_W-1:0]     alu_q, rd_q, link_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  retire;
    logic [DATA_W-1:0]     byte_sh, half_sh, word_sh, load_data;

    // LD on a 32-bit datapath aligns like LW, and off != 0 covers that case too
    function automatic logic misaligned(input logic [2:0] lt, input logic [OFF_W-1:0] off);
        return (lt[1:0] == 2'b01) ? off[0] :
               (lt[1:0] == 2'b10) ? (off[1:0] != 2'b00) :
               (lt == 3'b011)     ? (off != '0) : 1'b0;
    endfunction

    always_comb begin
        retire = !flushW && !stallW && validM &&
                 !(result_srcM == 2'b01 && misaligned(load_typeM, byte_offsetM));
        cnt_d  = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {valid_q, reg_write_q, src_q, lt_q, off_q, wr_q} <= '0;
            {alu_q, rd_q, link_q} <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (flushW) begin
                {valid_q, reg_write_q, src_q, lt_q, off_q, wr_q} <= '0;
                {alu_q, rd_q, link_q} <= '0;
            end else if (!stallW) begin
                {valid_q, reg_write_q, src_q, lt_q, off_q, wr_q} <=
                    {validM, reg_writeM, result_srcM, load_typeM, byte_offsetM, write_regM};
                {alu_q, rd_q, link_q} <= {alu_outM, read_dataM, linkM};
            end
        end
    end

    // Halfword/word lanes drop the low offset bits, so misaligned loads still read deterministic data
    always_comb begin
        byte_sh = rd_q >> {off_q, 3'b000};
        half_sh = rd_q >> {off_q[OFF_W-1:1], 4'b0000};
        word_sh = (DATA_W == 64) ? rd_q >> {off_q[OFF_W-1], 5'b00000} : rd_q;
        case (lt_q)
            3'b000:  load_data = DATA_W'($signed(byte_sh[7:0]));
            3'b001:  load_data = DATA_W'($signed(half_sh[15:0]));
            3'b010:  load_data = DATA_W'($signed(word_sh[31:0]));
            3'b100:  load_data = DATA_W'(byte_sh[7:0]);
            3'b101:  load_data = DATA_W'(half_sh[15:0]);
            3'b110:  load_data = DATA_W'(word_sh[31:0]);
            default: load_data = rd_q;
        endcase
    end

    always_comb begin
        validW           = valid_q;
        write_regW       = wr_q;
        load_misalignW   = valid_q && src_q == 2'b01 && misaligned(lt_q, off_q);
        reg_writeW       = valid_q && reg_write_q && !load_misalignW &&
                           !(ZERO_REG_HARDWIRED && wr_q == '0);
        result_to_writeW = (src_q == 2'b01) ? load_data : (src_q == 2'b10) ? link_q : alu_q;
        retired_cntW     = cnt_q;
    end
endmodule

// File: tb/tb_minisys_wb_stage.sv
// tb_minisys_wb_stage: 32-bit (4-bit counter) and 64-bit instances checked against a byte-level model.
module tb_minisys_wb_stage;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
    logic        validM = 1'b0, rwM = 1'b0;
    logic [1:0]  srcM = '0;
    logic [2:0]  ltM = '0, offM = '0;
    logic [4:0]  wrM = '0;
    logic [63:0] aluM = '0, rdM = '0, linkM = '0;
    logic        v32, rw32, mis32, v64, rw64, mis64;
    logic [4:0]  wr32, wr64;
    logic [31:0] res32;
    logic [63:0] res64;
    logic [3:0]  cnt32;
    logic [31:0] cnt64;
    int          vecs = 0, errs = 0;

    typedef struct packed {
        logic v, rw;
        logic [1:0] src;
        logic [2:0] lt, off;
        logic [4:0] wr;
        logic [63:0] alu, rd, link;
    } wb_t;
    wb_t m;
    int unsigned n32 = 0, n64 = 0;

    always #5 clk = ~clk;

    minisys_wb_stage #(.DATA_W(32), .CNT_W(4)) u32 (
        .clk(clk), .rst(rst), .stallW(stall), .flushW(flush), .validM(validM),
        .reg_writeM(rwM), .result_srcM(srcM), .load_typeM(ltM), .byte_offsetM(offM[1:0]),
        .write_regM(wrM), .alu_outM(aluM[31:0]), .read_dataM(rdM[31:0]), .linkM(linkM[31:0]),
        .validW(v32), .reg_writeW(rw32), .write_regW(wr32), .result_to_writeW(res32),
        .load_misalignW(mis32), .retired_cntW(cnt32));

    minisys_wb_stage #(.DATA_W(64)) u64 (
        .clk(clk), .rst(rst), .stallW(stall), .flushW(flush), .validM(validM),
        .reg_writeM(rwM), .result_srcM(srcM), .load_typeM(ltM), .byte_offsetM(offM),
        .write_regM(wrM), .alu_outM(aluM), .read_dataM(rdM), .linkM(linkM),
        .validW(v64), .reg_writeW(rw64), .write_regW(wr64), .result_to_writeW(res64),
        .load_misalignW(mis64), .retired_cntW(cnt64));

    function automatic int unsigned lsize(int w, logic [2:0] lt);
        return (lt == 3'd1 || lt == 3'd5) ? 1 << 1 :
               (lt == 3'd2 || lt == 3'd6) ? 4 :
               (lt == 3'd3) ? w / 8 : 1;
    endfunction

    function automatic int unsigned woff(int w, logic [2:0] off);
        return w == 64 ? int'(off) : int'(off) % 4;
    endfunction

    function automatic logic lmis(int w, logic [1:0] src, logic [2:0] lt, logic [2:0] off);
        return src == 2'd1 && (woff(w, off) % lsize(w, lt)) != 0;
    endfunction

    function automatic logic [63:0] wmask(int w);
        return w == 64 ? '1 : 64'hFFFF_FFFF;
    endfunction

    function automatic logic [63:0] ldata(int w, logic [2:0] lt, logic [2:0] off, logic [63:0] rd);
        int unsigned sz, bits, o;
        logic [63:0] v, fm;
        if (lt == 3'd7 || (lt == 3'd3 && w == 64)) return rd & wmask(w);
        sz = lsize(w, lt);
        bits = sz * 8;
        o = woff(w, off);
        fm = (64'd1 << bits) - 64'd1;
        v = (rd >> ((o / sz) * bits)) & fm;
        if (lt < 3'd4 && v[bits-1]) v = v | ~fm;
        return v & wmask(w);
    endfunction

    function automatic logic [63:0] eres(int w);
        return m.src == 2'd1 ? ldata(w, m.lt, m.off, m.rd) :
               m.src == 2'd2 ? m.link & wmask(w) : m.alu & wmask(w);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic e32, e64;
        e32 = m.v && lmis(32, m.src, m.lt, m.off);
        e64 = m.v && lmis(64, m.src, m.lt, m.off);
        chk("valid32", v32, m.v);
        chk("valid64", v64, m.v);
        chk("wreg32", wr32, m.wr);
        chk("wreg64", wr64, m.wr);
        chk("mis32", mis32, e32);
        chk("mis64", mis64, e64);
        chk("rw32", rw32, m.v && m.rw && !e32 && m.wr != 0);
        chk("rw64", rw64, m.v && m.rw && !e64 && m.wr != 0);
        chk("res32", res32, eres(32));
        chk("res64", res64, eres(64));
        chk("cnt32", cnt32, n32 % 16);
        chk("cnt64", cnt64, n64);
    endtask

    task automatic step();
        if (rst) begin
            m = '0;
            n32 = 0;
            n64 = 0;
        end else begin
            if (!flush && !stall && validM) begin
                if (!lmis(32, srcM, ltM, offM)) n32++;
                if (!lmis(64, srcM, ltM, offM)) n64++;
            end
            if (flush) m = '0;
            else if (!stall) m = '{validM, rwM, srcM, ltM, offM, wrM, aluM, rdM, linkM};
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic [1:0] src, input logic [2:0] lt, input logic [2:0] off,
                         input logic [4:0] wr, input logic [63:0] alu, input logic [63:0] rd,
                         input logic [63:0] link);
        validM = 1'b1;
        rwM = 1'b1;
        {srcM, ltM, offM, wrM, aluM, rdM, linkM} = {src, lt, off, wr, alu, rd, link};
    endtask

    initial begin
        step();
        chk("reset_res32", res32, 0);
        chk("reset_cnt32", cnt32, 0);
        rst = 1'b0;
        drive(2'd0, 3'd0, 3'd0, 5'd3, 64'h1234_5678, 64'd0, 64'd0);
        step();
        chk("alu_res", res32, 64'h1234_5678);
        chk("alu_rw", rw32, 1);
        chk("alu_cnt", cnt32, 1);
        drive(2'd1, 3'd0, 3'd3, 5'd5, 64'd0, 64'h80FF_7F01, 64'd0);
        step();
        chk("lb_off3", res32, 64'hFFFF_FF80);
        ltM = 3'd4;
        step();
        chk("lbu_off3", res32, 64'h0000_0080);
        ltM = 3'd1;
        offM = 3'd2;
        step();
        chk("lh_off2", res32, 64'hFFFF_80FF);
        ltM = 3'd5;
        offM = 3'd0;
        step();
        chk("lhu_off0", res32, 64'h0000_7F01);
        ltM = 3'd2;
        offM = 3'd2;
        step();
        chk("lw_mis", mis32, 1);
        chk("lw_mis_rw", rw32, 0);
        chk("lw_mis_cnt", cnt32, 5);
        ltM = 3'd1;
        offM = 3'd1;
        step();
        chk("lh_mis", mis32, 1);
        chk("lh_mis_rw", rw32, 0);
        chk("lh_mis_cnt", cnt32, 5);
        drive(2'd0, 3'd0, 3'd0, 5'd7, 64'hA5A5_5A5A, 64'd0, 64'd0);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'd2, 3'd0, 3'd0, 5'(i + 9), 64'(i), 64'd0, 64'h40 + 64'(i));
            step();
            chk("stall_res", res32, 64'hA5A5_5A5A);
            chk("stall_cnt", cnt32, 6);
        end
        flush = 1'b1;
        step();
        chk("flush_valid", v32, 0);
        chk("flush_rw", rw32, 0);
        chk("flush_cnt", cnt32, 6);
        {stall, flush} = 2'b00;
        drive(2'd0, 3'd0, 3'd0, 5'd0, 64'h55, 64'd0, 64'd0);
        step();
        chk("zero_reg_rw", rw32, 0);
        drive(2'd2, 3'd0, 3'd0, 5'd31, 64'h55, 64'd0, 64'h0040_0008);
        step();
        chk("link_res", res32, 64'h0040_0008);
        drive(2'd1, 3'd6, 3'd4, 5'd8, 64'd0, 64'h8000_0001_0000_0000, 64'd0);
        step();
        chk("lwu64_off4", res64, 64'h0000_0000_8000_0001);
        chk("lwu64_mis", mis64, 0);
        rst = 1'b1;
        #1;
        m = '0;
        n32 = 0;
        n64 = 0;
        check_all();
        step();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(2'd0, 3'd0, 3'd0, 5'(i + 1), 64'(i), 64'd0, 64'd0);
            step();
        end
        chk("cnt_wrap", cnt32, 1);
        chk("cnt64_17", cnt64, 17);
        for (int i = 0; i < 400; i++) begin
            validM = 1'($urandom);
            rwM = 1'($urandom);
            srcM = 2'($urandom_range(0, 3));
            ltM = 3'($urandom_range(0, 7));
            offM = 3'($urandom_range(0, 7));
            wrM = 5'($urandom);
            aluM = {$urandom, $urandom};
            rdM = {$urandom, $urandom};
            linkM = {$urandom, $urandom};
            stall = $urandom_range(0, 4) == 0;
            flush = $urandom_range(0, 7) == 0;
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/minisys_wb_stage.md
Name: minisys_wb_stage

Overview:
- Parametrised write-back stage: MEM/WB pipeline register plus result selection, load-data extraction and extension, misaligned-load detection, and retired-instruction counting.
- Sits between the MEM stage and the register file; its outputs drive the register-file write port and the forwarding unit.
- Replaces the plain two-input write-back mux.
- Supports a 32- or 64-bit datapath, three result sources, and stall/flush control.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, width of the retired-instruction counter.
- ZERO_REG_HARDWIRED, 1, when 1 a write to register 0 is suppressed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stallW  in  1  hold the WB register.
- flushW  in  1  load a bubble into the WB register.
- validM  in  1  MEM-stage instruction is valid.
- reg_writeM  in  1  instruction writes the register file.
- result_srcM  in  2  result source: 00 = ALU, 01 = memory, 10 = link, 11 = ALU.
- load_typeM  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 RAW.
- byte_offsetM  in  log2(DATA_W/8)  low address bits of the load.
- write_regM  in  REG_ADDR_W  destination register.
- alu_outM  in  DATA_W  ALU result.
- read_dataM  in  DATA_W  raw, naturally aligned memory word.
- linkM  in  DATA_W  return address (PC+8).
- validW  out  1  WB register holds a valid instruction.
- reg_writeW  out  1  effective register-file write enable.
- write_regW  out  REG_ADDR_W  destination register.
- result_to_writeW  out  DATA_W  write-back data.
- load_misalignW  out  1  the held load is misaligned.
- retired_cntW  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (asynchronous, active-high):
  - All WB register fields clear to 0, so every output is 0.
  - retired_cntW = 0.
  - Reset asserted mid-operation discards the held instruction immediately.
- Register update priority on each rising edge: flushW > stallW > normal capture.
  - flushW = 1: the register loads all-zero fields (validW = 0).
  - stallW = 1, flushW = 0: all fields hold.
  - Otherwise: the register captures the M-stage inputs.
- Latency: 1 cycle from M-stage inputs to W-stage outputs.
- Output logic is combinational from the registered fields only.
- Load extraction (little-endian, used only when result_src = 01):
  - Byte lane = offset × 8; halfword lane = offset[high bits] × 16; word lane = offset[high bit] × 32 when DATA_W = 64.
  - LB, LH, LW are sign-extended to DATA_W.
  - LBU, LHU, LWU are zero-extended.
  - LD passes the full 64-bit word.
  - When DATA_W = 32, LD and LWU behave as LW.
  - RAW passes read_data unmodified.
- Misalignment (when result_src = 01):
  - LH/LHU with offset[0] = 1.
  - LW/LWU with offset[1:0] ≠ 0.
  - LD with offset ≠ 0.
  - RAW is never misaligned.
- load_misalignW = validW AND memory source AND misaligned.
- reg_writeW = validW AND reg_write AND NOT load_misalignW AND NOT (ZERO_REG_HARDWIRED AND write_reg == 0).
- result_to_writeW is still driven when reg_writeW = 0; it is don't-care for the register file but deterministic.
- Retired-instruction counter:
  - Increments by 1 on an edge where the register performs a normal capture (flushW = 0, stallW = 0) with validM = 1 and the incoming instruction is not misaligned.
  - The misalignment check is evaluated on the M-stage inputs using the same rules as above.
  - Stalled or flushed edges never count.
  - The counter wraps modulo 2^CNT_W; no saturation.
- Simultaneous stallW and flushW: flush wins, and the counter does not increment.

Test Plan:
- Reset/capture: assert rst → all outputs 0. Release rst; present ALU source, alu_outM = 0x1234_5678, write_regM = 3, reg_writeM = 1 → next cycle result_to_writeW = 0x1234_5678, reg_writeW = 1, retired_cntW = 1.
- Load extension (DATA_W = 32): read_dataM = 0x80FF_7F01.
  - LB, offset 3 → 0xFFFF_FF80.
  - LBU, offset 3 → 0x0000_0080.
  - LH, offset 2 → 0xFFFF_80FF.
  - LHU, offset 0 → 0x0000_7F01.
- Misalign: LW with offset 2 → load_misalignW = 1, reg_writeW = 0, retired_cntW unchanged. LH with offset 1 → same response.
- Stall/flush: capture instruction A, then hold stallW for 3 cycles while the M-stage inputs change → outputs stay A and the counter is unchanged. Assert stallW and flushW together → validW = 0, reg_writeW = 0.
- Zero register and link source: write_regM = 0, reg_writeM = 1 → reg_writeW = 0. result_srcM = 10, linkM = 0x0040_0008 → result_to_writeW = 0x0040_0008.
- Counter wrap and 64-bit lanes: CNT_W = 4, 17 valid captures → retired_cntW = 1. DATA_W = 64, LWU, offset 4, read_dataM = 0x8000_0001_0000_0000 → result_to_writeW = 0x0000_0000_8000_0001.
